// File: rtl/alu_rs.sv
// ALU reservation station: a collapsing queue with oldest-first select and wakeup forwarding.
// Optional macro RS_SAME_CYCLE_WAKEUP_EN lets an entry issue in the cycle its wakeup arrives.

package alu_rs_pkg;
   localparam int PHYS_REG_BITS = 6;
   localparam int ROB_TAG_BITS  = 5;

   typedef struct packed {
      logic [PHYS_REG_BITS-1:0] prs1;
      logic                     prs1_ready;
      logic [PHYS_REG_BITS-1:0] prs2;
      logic                     prs2_ready;
      logic [PHYS_REG_BITS-1:0] prd;
      logic [ROB_TAG_BITS-1:0]  rob_tag;
      logic                     reg_write;
      logic                     alu_src;
      logic [31:0]              immediate;
      logic [3:0]               alu_op;
   } rs_entry_t;
endpackage

module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        dispatch_valid,
   input  rs_entry_t                   dispatch_entry,
   output logic                        dispatch_ready,
   input  logic                        wakeup0_en,
   input  logic [PHYS_REG_BITS-1:0]    wakeup0_prd,
   input  logic                        wakeup1_en,
   input  logic [PHYS_REG_BITS-1:0]    wakeup1_prd,
   input  logic                        alu_ready,
   output logic                        issue_en,
   output rs_entry_t                   issue_entry,
   output logic [$clog2(RS_DEPTH):0]   occupancy,
   input  logic                        flush
);

   localparam int IDX_W = $clog2(RS_DEPTH);
   localparam int OCC_W = IDX_W + 1;

   rs_entry_t           r_entry [RS_DEPTH];
   logic [OCC_W-1:0]    r_occ;

   rs_entry_t           w_cand  [RS_DEPTH];
   rs_entry_t           w_up    [RS_DEPTH];
   rs_entry_t           w_next  [RS_DEPTH];
   logic [RS_DEPTH-1:0] w_elig;
   logic [IDX_W-1:0]    w_sel;
   logic                w_any;
   logic                w_disp_acc;
   logic [OCC_W-1:0]    w_disp_idx;
   logic [OCC_W-1:0]    w_occ_next;

   // Both ports are OR-ed in, so a double match on one entry is conflict-free.
   function automatic rs_entry_t f_wake(
      input rs_entry_t                e,
      input logic                     en0,
      input logic [PHYS_REG_BITS-1:0] prd0,
      input logic                     en1,
      input logic [PHYS_REG_BITS-1:0] prd1
   );
      rs_entry_t v_e;
      v_e            = e;
      v_e.prs1_ready = e.prs1_ready | (en0 && (e.prs1 == prd0)) | (en1 && (e.prs1 == prd1));
      v_e.prs2_ready = e.prs2_ready | (en0 && (e.prs2 == prd0)) | (en1 && (e.prs2 == prd1));
      return v_e;
   endfunction

   // Per-entry eligibility; valid entries are exactly indices below r_occ.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_SAME_CYCLE_WAKEUP_EN
         w_cand[i] = f_wake(r_entry[i], wakeup0_en, wakeup0_prd, wakeup1_en, wakeup1_prd);
`else
         w_cand[i] = r_entry[i];
`endif
         w_elig[i] = (OCC_W'(i) < r_occ) && w_cand[i].prs1_ready &&
                     (w_cand[i].prs2_ready || w_cand[i].alu_src);
      end
   end

   // Oldest-first select: scanning downwards leaves the lowest eligible index.
   always_comb begin
      w_sel = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         w_sel = w_elig[i] ? IDX_W'(i) : w_sel;
      end
   end

   assign w_any          = |w_elig;
   assign issue_en       = alu_ready && w_any && !flush;
   assign issue_entry    = w_any ? w_cand[w_sel] : '0;
   assign dispatch_ready = (r_occ < OCC_W'(RS_DEPTH));
   assign occupancy      = r_occ;

   assign w_disp_acc = dispatch_valid && dispatch_ready && !flush;
   assign w_disp_idx = issue_en ? (r_occ - OCC_W'(1)) : r_occ;
   assign w_occ_next = flush ? '0 : (r_occ + OCC_W'(w_disp_acc) - OCC_W'(issue_en));

   // Next queue contents: collapse over the issued slot, apply wakeups, insert dispatch.
   always_comb begin
      for (int i = 0; i < RS_DEPTH - 1; i++) begin
         w_up[i] = r_entry[i+1];
      end
      w_up[RS_DEPTH-1] = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         w_next[i] = (issue_en && (IDX_W'(i) >= w_sel)) ? w_up[i] : r_entry[i];
         w_next[i] = f_wake(w_next[i], wakeup0_en, wakeup0_prd, wakeup1_en, wakeup1_prd);
         w_next[i] = (w_disp_acc && (OCC_W'(i) == w_disp_idx)) ?
                     f_wake(dispatch_entry, wakeup0_en, wakeup0_prd, wakeup1_en, wakeup1_prd) :
                     w_next[i];
      end
   end

   // State register; reset and flush both empty the queue and clear ready bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_occ <= '0;
         for (int i = 0; i < RS_DEPTH; i++) begin
            r_entry[i] <= '0;
         end
      end else begin
         r_occ <= w_occ_next;
         for (int i = 0; i < RS_DEPTH; i++) begin
            r_entry[i] <= flush ? '0 : w_next[i];
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs; expectations follow RS_SAME_CYCLE_WAKEUP_EN if defined.

module tb_alu_rs;
   import alu_rs_pkg::*;

   logic                     clk;
   logic                     rst;
   logic                     dispatch_valid;
   rs_entry_t                dispatch_entry;
   logic                     dispatch_ready;
   logic                     wakeup0_en;
   logic [PHYS_REG_BITS-1:0] wakeup0_prd;
   logic                     wakeup1_en;
   logic [PHYS_REG_BITS-1:0] wakeup1_prd;
   logic                     alu_ready;
   logic                     issue_en;
   rs_entry_t                issue_entry;
   logic [3:0]               occupancy;
   logic                     flush;

   int n_checks = 0;
   int n_fail   = 0;

   alu_rs #(.RS_DEPTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .dispatch_valid (dispatch_valid),
      .dispatch_entry (dispatch_entry),
      .dispatch_ready (dispatch_ready),
      .wakeup0_en     (wakeup0_en),
      .wakeup0_prd    (wakeup0_prd),
      .wakeup1_en     (wakeup1_en),
      .wakeup1_prd    (wakeup1_prd),
      .alu_ready      (alu_ready),
      .issue_en       (issue_en),
      .issue_entry    (issue_entry),
      .occupancy      (occupancy),
      .flush          (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic rs_entry_t mk(input int p1, input bit r1, input int p2, input bit r2,
                                    input int tag, input bit src);
      rs_entry_t e;
      e            = '0;
      e.prs1       = PHYS_REG_BITS'(p1);
      e.prs1_ready = r1;
      e.prs2       = PHYS_REG_BITS'(p2);
      e.prs2_ready = r2;
      e.prd        = PHYS_REG_BITS'(tag);
      e.rob_tag    = ROB_TAG_BITS'(tag);
      e.reg_write  = 1'b1;
      e.alu_src    = src;
      e.immediate  = 32'(tag);
      return e;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; dispatch_valid = 1'b0; dispatch_entry = '0; alu_ready = 1'b0; flush = 1'b0;
      wakeup0_en = 1'b0; wakeup0_prd = '0; wakeup1_en = 1'b0; wakeup1_prd = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("reset_occ", 64'(occupancy), 64'd0);
      check("reset_issue_en", 64'(issue_en), 64'd0);
      check("reset_dispatch_ready", 64'(dispatch_ready), 64'd1);

      // single ready entry issues the cycle after dispatch
      alu_ready = 1'b1; dispatch_valid = 1'b1; dispatch_entry = mk(1, 1, 2, 1, 3, 0);
      tick();
      dispatch_valid = 1'b0;
      #1;
      check("single_issue_en", 64'(issue_en), 64'd1);
      check("single_tag", 64'(issue_entry.rob_tag), 64'd3);
      check("single_occ", 64'(occupancy), 64'd1);
      tick();
      check("single_occ_after", 64'(occupancy), 64'd0);
      check("single_issue_after", 64'(issue_en), 64'd0);

      // fill with 8 waiting entries, then wake all and drain in order
      alu_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         dispatch_valid = 1'b1; dispatch_entry = mk(5, 0, 1, 1, k, 0);
         tick();
      end
      dispatch_entry = mk(1, 1, 1, 1, 31, 0);
      #1;
      check("full_occ", 64'(occupancy), 64'd8);
      check("full_dispatch_ready", 64'(dispatch_ready), 64'd0);
      check("full_no_issue", 64'(issue_en), 64'd0);
      wakeup0_en = 1'b1; wakeup0_prd = 6'd5;
      tick();
      dispatch_valid = 1'b0; wakeup0_en = 1'b0;
      check("full_drop_occ", 64'(occupancy), 64'd8);
      alu_ready = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         check("drain_issue_en", 64'(issue_en), 64'd1);
         check("drain_tag", 64'(issue_entry.rob_tag), 64'(k));
         if (k == 0) check("drain_ready_indep_of_issue", 64'(dispatch_ready), 64'd0);
         tick();
      end
      check("drain_occ", 64'(occupancy), 64'd0);

      // younger ready entry bypasses older waiting one; same-cycle wakeup behaviour
      alu_ready = 1'b0;
      dispatch_valid = 1'b1; dispatch_entry = mk(3, 0, 1, 1, 10, 0);
      tick();
      dispatch_entry = mk(2, 1, 1, 1, 11, 0);
      tick();
      dispatch_valid = 1'b0; alu_ready = 1'b1;
      #1;
      check("bypass_issue_en", 64'(issue_en), 64'd1);
      check("bypass_tag", 64'(issue_entry.rob_tag), 64'd11);
      check("bypass_occ", 64'(occupancy), 64'd2);
      tick();
      check("wait_occ", 64'(occupancy), 64'd1);
      check("wait_issue_en", 64'(issue_en), 64'd0);
      check("wait_issue_entry_zero", 64'(issue_entry), 64'd0);
      wakeup0_en = 1'b1; wakeup0_prd = 6'd3;
      #1;
`ifdef RS_SAME_CYCLE_WAKEUP_EN
      check("wake_cycle_issue_en", 64'(issue_en), 64'd1);
      check("wake_cycle_tag", 64'(issue_entry.rob_tag), 64'd10);
`else
      check("wake_cycle_issue_en", 64'(issue_en), 64'd0);
`endif
      tick();
      wakeup0_en = 1'b0;
      #1;
`ifdef RS_SAME_CYCLE_WAKEUP_EN
      check("wake_next_occ", 64'(occupancy), 64'd0);
`else
      check("wake_next_issue_en", 64'(issue_en), 64'd1);
      check("wake_next_tag", 64'(issue_entry.rob_tag), 64'd10);
`endif
      tick();
      check("wake_done_occ", 64'(occupancy), 64'd0);

      // wakeup coincident with dispatch is not lost
      alu_ready = 1'b0;
      dispatch_valid = 1'b1; dispatch_entry = mk(2, 1, 9, 0, 12, 0);
      wakeup1_en = 1'b1; wakeup1_prd = 6'd9;
      tick();
      dispatch_valid = 1'b0; wakeup1_en = 1'b0; alu_ready = 1'b1;
      #1;
      check("lost_wake_issue_en", 64'(issue_en), 64'd1);
      check("lost_wake_tag", 64'(issue_entry.rob_tag), 64'd12);
      check("lost_wake_prs2_ready", 64'(issue_entry.prs2_ready), 64'd1);
      tick();

      // both wakeup ports hit one entry in the same cycle
      alu_ready = 1'b0;
      dispatch_valid = 1'b1; dispatch_entry = mk(4, 0, 6, 0, 13, 0);
      tick();
      dispatch_valid = 1'b0;
      wakeup0_en = 1'b1; wakeup0_prd = 6'd4; wakeup1_en = 1'b1; wakeup1_prd = 6'd6;
      tick();
      wakeup0_en = 1'b0; wakeup1_en = 1'b0; alu_ready = 1'b1;
      #1;
      check("dual_wake_issue_en", 64'(issue_en), 64'd1);
      check("dual_wake_tag", 64'(issue_entry.rob_tag), 64'd13);
      tick();

      // immediate operand ignores prs2 readiness
      alu_ready = 1'b0;
      dispatch_valid = 1'b1; dispatch_entry = mk(4, 1, 7, 0, 14, 1);
      tick();
      dispatch_valid = 1'b0; alu_ready = 1'b1;
      #1;
      check("alu_src_issue_en", 64'(issue_en), 64'd1);
      check("alu_src_tag", 64'(issue_entry.rob_tag), 64'd14);
      tick();

      // dispatch and issue in the same cycle land at occupancy-1
      alu_ready = 1'b0;
      dispatch_valid = 1'b1; dispatch_entry = mk(1, 1, 1, 1, 15, 0);
      tick();
      alu_ready = 1'b1; dispatch_entry = mk(1, 1, 1, 1, 16, 0);
      #1;
      check("same_cycle_tag", 64'(issue_entry.rob_tag), 64'd15);
      tick();
      dispatch_valid = 1'b0;
      #1;
      check("same_cycle_occ", 64'(occupancy), 64'd1);
      check("same_cycle_next_tag", 64'(issue_entry.rob_tag), 64'd16);
      tick();
      check("same_cycle_empty", 64'(occupancy), 64'd0);

      // flush with a concurrent dispatch
      alu_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         dispatch_valid = 1'b1; dispatch_entry = mk(1, 1, 1, 1, 20 + k, 0);
         tick();
      end
      dispatch_valid = 1'b0;
      #1;
      check("preflush_occ", 64'(occupancy), 64'd5);
      flush = 1'b1; dispatch_valid = 1'b1; dispatch_entry = mk(1, 1, 1, 1, 25, 0); alu_ready = 1'b1;
      #1;
      check("flush_no_issue", 64'(issue_en), 64'd0);
      tick();
      flush = 1'b0; dispatch_valid = 1'b0;
      #1;
      check("flush_occ", 64'(occupancy), 64'd0);
      check("flush_issue_en", 64'(issue_en), 64'd0);
      tick();
      check("flush_dropped_never_issues", 64'(issue_en), 64'd0);

      // reset mid-operation overrides dispatch, issue and wakeup
      alu_ready = 1'b0;
      dispatch_valid = 1'b1; dispatch_entry = mk(1, 1, 1, 1, 26, 0);
      tick(); tick();
      rst = 1'b1; alu_ready = 1'b1; wakeup0_en = 1'b1; wakeup0_prd = 6'd1;
      tick();
      rst = 1'b0; dispatch_valid = 1'b0; wakeup0_en = 1'b0;
      #1;
      check("midreset_occ", 64'(occupancy), 64'd0);
      check("midreset_issue_en", 64'(issue_en), 64'd0);
      check("midreset_dispatch_ready", 64'(dispatch_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
